// File: rtl/ras_pkg.sv
// Shared types and default sizing for the return-address stack.
// Reused by ras_ctrl and the ras_bram instances beside it.
package ras_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } ras_state_e;

  localparam int RAS_DEPTH = 1024;
  localparam int RAS_WIDTH = 32;

endpackage

// File: rtl/ras_ctrl.sv
// Return-address-stack controller with a cached top-of-stack, driving BRAM port A.
// Optional RAS_CHECKPOINT_EN adds checkpoint outputs and a restore path.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  parameter  int WIDTH = RAS_WIDTH,
  localparam int PTR   = $clog2(DEPTH),
  localparam int CW    = PTR + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop_req,
  output logic             ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_addr,
  output logic             pop_empty,
  output logic [CW-1:0]    count,
  output logic             ram_rea,
  output logic             ram_wea,
  output logic [PTR-1:0]   ram_raddr,
  output logic [PTR-1:0]   ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
`ifdef RAS_CHECKPOINT_EN
  input  logic             restore_valid,
  input  logic [PTR-1:0]   restore_top,
  input  logic [CW-1:0]    restore_count,
  output logic [PTR-1:0]   ckpt_top,
  output logic [CW-1:0]    ckpt_count,
`endif
  input  logic [WIDTH-1:0] ram_dout
);

  ras_state_e       r_state;
  ras_state_e       w_next_state;

  logic [PTR-1:0]   r_top;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_tos;
  logic             r_pop_valid;
  logic [WIDTH-1:0] r_pop_addr;
  logic             r_pop_empty;

  logic [PTR-1:0]   w_top_n;
  logic [CW-1:0]    w_count_n;
  logic [WIDTH-1:0] w_tos_n;
  logic             w_pv_n;
  logic [WIDTH-1:0] w_pa_n;
  logic             w_pe_n;

  logic             w_idle;
  logic             w_restore;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_multi;
  logic             w_swap;
  logic             w_push_only;
  logic             w_pop_only;
  logic [PTR-1:0]   w_top_inc;
  logic [PTR-1:0]   w_top_dec;

`ifdef RAS_CHECKPOINT_EN
  assign w_restore  = restore_valid & ~rst;
  assign ckpt_top   = r_top;
  assign ckpt_count = r_count;
`else
  assign w_restore  = 1'b0;
`endif

  assign w_idle    = (r_state == IDLE);
  assign w_push    = push_valid & w_idle & ~rst & ~w_restore;
  assign w_pop     = pop_req & w_idle & ~rst & ~w_restore;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_multi   = (r_count > CW'(1));
  assign w_top_inc = r_top + PTR'(1);
  assign w_top_dec = r_top - PTR'(1);

  // Return-then-call on a non-empty stack replaces the top in place
  assign w_swap      = w_push & w_pop & ~w_empty;
  assign w_push_only = w_push & ~w_swap;
  assign w_pop_only  = w_pop & ~w_push & ~w_empty;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pop_only && w_multi) begin
          w_next_state = REFILL;
        end
      end
      REFILL:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
`ifdef RAS_CHECKPOINT_EN
    if (w_restore) begin
      w_next_state = (restore_count != '0) ? REFILL : IDLE;
    end
`endif
  end

  // FSM outputs and BRAM port A
  always_comb begin
    ready     = w_idle;
    ram_rea   = 1'b0;
    ram_wea   = 1'b0;
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    unique case (1'b1)
      w_swap: begin
        ram_wea   = 1'b1;
        ram_waddr = r_top;
        ram_wdata = push_addr;
      end
      w_push_only: begin
        ram_wea   = 1'b1;
        ram_waddr = w_top_inc;
        ram_wdata = push_addr;
      end
      w_pop_only: begin
        ram_rea   = w_multi;
        ram_raddr = w_multi ? w_top_dec : '0;
      end
      default: ;
    endcase
`ifdef RAS_CHECKPOINT_EN
    if (w_restore) begin
      ram_rea   = (restore_count != '0);
      ram_raddr = restore_top;
    end
`endif
  end

  // Stack datapath next values
  always_comb begin
    w_top_n   = r_top;
    w_count_n = r_count;
    w_tos_n   = r_tos;
    w_pv_n    = 1'b0;
    w_pa_n    = '0;
    w_pe_n    = 1'b0;
    if (r_state == REFILL) begin
      w_tos_n = ram_dout;
    end
    if (w_pop) begin
      w_pv_n = 1'b1;
      w_pe_n = w_empty;
      w_pa_n = w_empty ? '0 : r_tos;
    end
    unique case (1'b1)
      w_swap: begin
        w_tos_n = push_addr;
      end
      w_push_only: begin
        w_top_n   = w_top_inc;
        w_count_n = w_full ? r_count : r_count + CW'(1);
        w_tos_n   = push_addr;
      end
      w_pop_only: begin
        w_top_n   = w_top_dec;
        w_count_n = r_count - CW'(1);
        if (!w_multi) begin
          w_tos_n = '0;
        end
      end
      default: ;
    endcase
`ifdef RAS_CHECKPOINT_EN
    if (w_restore) begin
      w_top_n   = restore_top;
      w_count_n = restore_count;
      w_tos_n   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top       <= PTR'(DEPTH - 1);
      r_count     <= '0;
      r_tos       <= '0;
      r_pop_valid <= 1'b0;
      r_pop_addr  <= '0;
      r_pop_empty <= 1'b0;
    end else begin
      r_top       <= w_top_n;
      r_count     <= w_count_n;
      r_tos       <= w_tos_n;
      r_pop_valid <= w_pv_n;
      r_pop_addr  <= w_pa_n;
      r_pop_empty <= w_pe_n;
    end
  end

  assign pop_valid = r_pop_valid;
  assign pop_addr  = r_pop_addr;
  assign pop_empty = r_pop_empty;
  assign count     = r_count;

endmodule
